param_lock: RTL and testbench
=============================

# param_lock

Parametrised digital code lock with attempt counting, timed unlock, brute-force lockout and run-time re-programmable code. Two push-button inputs (b0, b1) enter one binary digit per clock. Each attempt is exactly CODE_LEN digits and is checked as a whole. The block sits between the debounced button front-end and the actuator driver, and replaces the fixed-sequence detector in the lock subsystem.

## Interface
- CODE_LEN, 5: digits per attempt (>=2)
- CODE, 5'b01011: code loaded at reset, CODE_LEN bits, first digit = MSB
- MAX_FAIL, 3: consecutive wrong attempts that trigger lockout (>=1)
- UNLOCK_CYCLES, 8: cycles unlock is held high
- LOCKOUT_CYCLES, 16: cycles locked_out is held high
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; low on a rising edge resets everything
- b0  in  1  digit-0 button
- b1  in  1  digit-1 button
- prog  in  1  request code re-programming (honoured only while unlock=1)
- unlock  out  1  lock open
- locked_out  out  1  lockout active
- prog_active  out  1  new-code entry in progress
- digit_cnt  out  $clog2(CODE_LEN+1)  digits collected in current attempt
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive wrong attempts

## Operation
- Every clock edge samples the buttons as a per-cycle level:
  - b0=1, b1=0: digit 0.
  - b0=0, b1=1: digit 1.
  - Both high: CLEAR.
  - Both low: no event.
  - A button held for N cycles enters N digits.
- States: IDLE, OPEN, PROG, LOCKOUT. Reset gives IDLE, stored code = CODE, and every output 0.
- IDLE:
  - Each digit shifts into the entry register (left shift, LSB in) and increments digit_cnt.
  - CLEAR sets digit_cnt=0. It is not a failure.
  - On the edge that samples digit number CODE_LEN, compare the full entry to the stored code and set digit_cnt=0.
  - Match: go to OPEN and set fail_cnt=0.
  - Mismatch: fail_cnt+1. If the new value equals MAX_FAIL, go to LOCKOUT; otherwise stay in IDLE.
- OPEN:
  - unlock=1. Buttons are ignored.
  - prog=1 on any OPEN edge: go to PROG.
  - Otherwise return to IDLE after UNLOCK_CYCLES.
  - prog has priority over the timer on the final OPEN cycle.
- PROG:
  - prog_active=1, unlock=0.
  - Digits fill the entry register and digit_cnt.
  - On the CODE_LEN-th digit, the entry becomes the stored code; go to IDLE with fail_cnt=0.
  - CLEAR aborts to IDLE with the stored code unchanged.
  - No timeout.
- LOCKOUT:
  - locked_out=1. Buttons and prog are ignored. digit_cnt stays 0.
  - After LOCKOUT_CYCLES, go to IDLE with fail_cnt=0.
- CLEAR and a digit cannot coincide, because the encoding is exclusive.
- Digit order: the first digit entered is compared with stored-code bit CODE_LEN-1.
- The stored code is lost only on reset.
- Counters never wrap:
  - fail_cnt saturates at MAX_FAIL and leaves LOCKOUT at 0.
  - digit_cnt never exceeds CODE_LEN-1 when observed.

## Timing
- All outputs are registered and reflect state after each edge.
- unlock rises immediately after the edge that samples the last correct digit. It stays high for exactly UNLOCK_CYCLES edges, then falls, unless prog moves the block to PROG.
- locked_out rises after the edge that samples the MAX_FAIL-th wrong final digit. It stays high for exactly LOCKOUT_CYCLES cycles.
- The first digit accepted after OPEN or LOCKOUT ends is on the edge following the exit edge.
- Idle cycles (no event) between digits are allowed in any number and do not reset the entry.
- Reset low on any edge, including mid-attempt, OPEN, PROG or LOCKOUT:
  - Next state IDLE, all outputs 0.
  - Stored code reverts to CODE.
  - Takes precedence over every other input.

## Test plan
- Reset, then enter 0,1,0,1,1 on consecutive edges -> unlock=1 right after the 5th-digit edge, for exactly 8 cycles; fail_cnt stays 0.
- Enter 1,1,1,1,1 three times -> fail_cnt goes 1, 2, then locked_out=1 for exactly 16 cycles with buttons toggling; afterwards fail_cnt=0 and 01011 unlocks.
- Enter 0,1, then both high, then 0,1,0,1,1 -> digit_cnt goes 1, 2, 0; no failure counted; unlock follows the final digit.
- Unlock, assert prog in cycle 3 of OPEN -> unlock falls and prog_active=1. Enter 1,1,1,0,0 -> prog_active falls. 01011 now fails (fail_cnt=1) and 11100 unlocks (fail_cnt=0).
- Enter 0,1 with idle gaps of 4 cycles between digits, then 0,1,1 -> unlock.
- Drive reset low in PROG after 2 new digits, and separately mid-LOCKOUT -> all outputs 0 the next cycle, and 01011 unlocks afterwards.

Source files
------------

// File: rtl/param_lock.sv
// param_lock: code lock, CODE_LEN-digit attempts, timed unlock, brute-force lockout, re-programmable code.
// Latency: outputs registered, one edge after the sampled digit; no backpressure, one digit per cycle.
module param_lock #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] CODE           = 5'b01011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_b0,
  input  logic                            i_b1,
  input  logic                            i_prog,
  output logic                            o_unlock,
  output logic                            o_locked_out,
  output logic                            o_prog_active,
  output logic [$clog2(CODE_LEN+1)-1:0]   o_digit_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]   o_fail_cnt
);

  localparam int DW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PROG    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t              r_state;
  logic [CODE_LEN-1:0] r_entry;
  logic [CODE_LEN-1:0] r_code;
  logic [DW-1:0]       r_dcnt;
  logic [FW-1:0]       r_fcnt;
  logic [TW-1:0]       r_timer;
  logic                r_unlock;
  logic                r_locked_out;
  logic                r_prog_active;

  state_t              w_state_nxt;
  logic [CODE_LEN-1:0] w_entry_nxt;
  logic [CODE_LEN-1:0] w_code_nxt;
  logic [DW-1:0]       w_dcnt_nxt;
  logic [FW-1:0]       w_fcnt_nxt;
  logic [TW-1:0]       w_timer_nxt;

  logic                w_digit_vld;
  logic                w_clear;
  logic                w_last;
  logic [CODE_LEN-1:0] w_shifted;

  // Exactly one button high is a digit (b1 carries its value); both high is CLEAR.
  assign w_digit_vld = i_b0 ^ i_b1;
  assign w_clear     = i_b0 & i_b1;
  assign w_shifted   = {r_entry[CODE_LEN-2:0], i_b1};
  assign w_last      = (r_dcnt == DW'(CODE_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_entry_nxt = r_entry;
    w_code_nxt  = r_code;
    w_dcnt_nxt  = r_dcnt;
    w_fcnt_nxt  = r_fcnt;
    w_timer_nxt = r_timer;

    case (r_state)
      ST_IDLE: begin
        if (w_clear) begin
          w_dcnt_nxt = '0;
        end else if (w_digit_vld) begin
          w_entry_nxt = w_shifted;
          if (w_last) begin
            w_dcnt_nxt  = '0;
            w_timer_nxt = '0;
            if (w_shifted == r_code) begin
              w_state_nxt = ST_OPEN;
              w_fcnt_nxt  = '0;
            end else if (r_fcnt == FW'(MAX_FAIL - 1)) begin
              // fail_cnt parks at MAX_FAIL for the whole lockout
              w_state_nxt = ST_LOCKOUT;
              w_fcnt_nxt  = FW'(MAX_FAIL);
            end else begin
              w_fcnt_nxt = r_fcnt + FW'(1);
            end
          end else begin
            w_dcnt_nxt = r_dcnt + DW'(1);
          end
        end
      end

      ST_OPEN: begin
        if (i_prog) begin
          w_state_nxt = ST_PROG;
          w_dcnt_nxt  = '0;
        end else if (r_timer == TW'(UNLOCK_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      ST_PROG: begin
        if (w_clear) begin
          w_state_nxt = ST_IDLE;
          w_dcnt_nxt  = '0;
        end else if (w_digit_vld) begin
          w_entry_nxt = w_shifted;
          if (w_last) begin
            w_code_nxt  = w_shifted;
            w_state_nxt = ST_IDLE;
            w_dcnt_nxt  = '0;
            w_fcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt = r_dcnt + DW'(1);
          end
        end
      end

      ST_LOCKOUT: begin
        w_dcnt_nxt = '0;
        if (r_timer == TW'(LOCKOUT_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_fcnt_nxt  = '0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_dcnt_nxt  = '0;
        w_fcnt_nxt  = '0;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_entry       <= '0;
      r_code        <= CODE;
      r_dcnt        <= '0;
      r_fcnt        <= '0;
      r_timer       <= '0;
      r_unlock      <= 1'b0;
      r_locked_out  <= 1'b0;
      r_prog_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_entry       <= w_entry_nxt;
      r_code        <= w_code_nxt;
      r_dcnt        <= w_dcnt_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_timer       <= w_timer_nxt;
      r_unlock      <= (w_state_nxt == ST_OPEN);
      r_locked_out  <= (w_state_nxt == ST_LOCKOUT);
      r_prog_active <= (w_state_nxt == ST_PROG);
    end
  end

  assign o_unlock      = r_unlock;
  assign o_locked_out  = r_locked_out;
  assign o_prog_active = r_prog_active;
  assign o_digit_cnt   = r_dcnt;
  assign o_fail_cnt    = r_fcnt;

endmodule

// File: tb/tb_param_lock.sv
// Directed stimulus for param_lock; expected outputs are queued per edge and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_param_lock;

  logic       clk = 1'b0;
  logic       rst_n, b0, b1, prog;
  logic       unlock, locked_out, prog_active;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  param_lock #(
    .CODE_LEN(5), .CODE(5'b01011), .MAX_FAIL(3),
    .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_b0(b0), .i_b1(b1), .i_prog(prog),
    .o_unlock(unlock), .o_locked_out(locked_out), .o_prog_active(prog_active),
    .o_digit_cnt(digit_cnt), .o_fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  u, lo, pa;
    int    dc, fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [4:0] K0 = 5'b01011;
  localparam logic [4:0] K1 = 5'b11100;

  // Monitor: each negedge checks the outputs produced by the preceding posedge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({unlock, locked_out, prog_active, digit_cnt, fail_cnt} !==
          {e.u, e.lo, e.pa, 3'(e.dc), 2'(e.fc)}) begin
        n_bad++;
        $display("FAIL %s: got u=%0b lo=%0b pa=%0b dc=%0d fc=%0d, expected u=%0b lo=%0b pa=%0b dc=%0d fc=%0d",
                 e.tag, unlock, locked_out, prog_active, digit_cnt, fail_cnt,
                 e.u, e.lo, e.pa, e.dc, e.fc);
      end
    end
  end

  task automatic cyc(input string tag, input logic ib0, ib1, ipr, irn,
                     input logic u, l, p, input int d, f);
    exp_t e;
    b0 = ib0; b1 = ib1; prog = ipr; rst_n = irn;
    e.tag = tag; e.u = u; e.lo = l; e.pa = p; e.dc = d; e.fc = f;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic dig(input string tag, input logic d,
                     input logic u, l, p, input int dc, fc);
    cyc(tag, !d, d, 1'b0, 1'b1, u, l, p, dc, fc);
  endtask

  task automatic idle(input string tag, input logic u, l, p, input int dc, fc);
    cyc(tag, 1'b0, 1'b0, 1'b0, 1'b1, u, l, p, dc, fc);
  endtask

  // Full attempt from digit_cnt=0; ok selects the match or mismatch outcome.
  task automatic enter(input string tag, input logic [4:0] code, input int fc0, input bit ok);
    int f1;
    for (int i = 0; i < 4; i++)
      dig($sformatf("%s.d%0d", tag, i + 1), code[4-i], 1'b0, 1'b0, 1'b0, i + 1, fc0);
    if (ok) begin
      dig($sformatf("%s.open", tag), code[0], 1'b1, 1'b0, 1'b0, 0, 0);
    end else begin
      f1 = fc0 + 1;
      dig($sformatf("%s.fail", tag), code[0], 1'b0, (f1 == 3), 1'b0, 0, f1);
    end
  endtask

  // Remaining 7 OPEN cycles with buttons pressed (ignored), then the exit edge.
  task automatic open_hold(input string tag);
    for (int i = 0; i < 7; i++)
      dig($sformatf("%s.open%0d", tag, i + 2), i[0], 1'b1, 1'b0, 1'b0, 0, 0);
    dig($sformatf("%s.openexit", tag), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic lock_hold(input string tag, input int n);
    for (int i = 0; i < n; i++)
      cyc($sformatf("%s.lock%0d", tag, i + 2), (i % 3) != 1, (i % 3) != 0, 1'b1, 1'b1,
          1'b0, 1'b1, 1'b0, 0, 3);
  endtask

  initial begin
    b0 = 1'b0; b1 = 1'b0; prog = 1'b0; rst_n = 1'b0;

    cyc("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("rst1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle("rst2", 1'b0, 1'b0, 1'b0, 0, 0);

    // Correct code, 8-cycle unlock
    enter("t1", K0, 0, 1'b1);
    open_hold("t1");

    // Three wrong attempts -> 16-cycle lockout, then the code works
    enter("t2a", 5'b11111, 0, 1'b0);
    enter("t2b", 5'b11111, 1, 1'b0);
    enter("t2c", 5'b11111, 2, 1'b0);
    lock_hold("t2", 14);
    cyc("t2.lock16", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 3);
    dig("t2.lockexit", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    enter("t2d", K0, 0, 1'b1);
    open_hold("t2d");

    // CLEAR mid-attempt is not a failure
    dig("t3.d1", 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    dig("t3.d2", 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    cyc("t3.clr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    enter("t3", K0, 0, 1'b1);
    open_hold("t3");

    // Re-program to 11100 from OPEN cycle 3
    enter("t4", K0, 0, 1'b1);
    idle("t4.open2", 1'b1, 1'b0, 1'b0, 0, 0);
    idle("t4.open3", 1'b1, 1'b0, 1'b0, 0, 0);
    cyc("t4.prog", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    dig("t4.p1", 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
    dig("t4.p2", 1'b1, 1'b0, 1'b0, 1'b1, 2, 0);
    dig("t4.p3", 1'b1, 1'b0, 1'b0, 1'b1, 3, 0);
    dig("t4.p4", 1'b0, 1'b0, 1'b0, 1'b1, 4, 0);
    dig("t4.p5", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    enter("t4old", K0, 0, 1'b0);
    enter("t4new", K1, 1, 1'b1);
    // prog wins over the timer on the final OPEN edge; CLEAR then aborts
    for (int i = 0; i < 7; i++)
      idle($sformatf("t4pri.open%0d", i + 2), 1'b1, 1'b0, 1'b0, 0, 0);
    cyc("t4pri.prog", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    dig("t4pri.p1", 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
    cyc("t4pri.abort", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    enter("t4keep", K1, 0, 1'b1);
    open_hold("t4keep");

    // Reset in PROG restores the reset code
    enter("t6a", K1, 0, 1'b1);
    cyc("t6a.prog", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    dig("t6a.p1", 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
    dig("t6a.p2", 1'b0, 1'b0, 1'b0, 1'b1, 2, 0);
    cyc("t6a.rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle("t6a.post", 1'b0, 1'b0, 1'b0, 0, 0);

    // Idle gaps between digits keep the entry
    dig("t5.d1", 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    for (int i = 0; i < 4; i++) idle($sformatf("t5.gapA%0d", i), 1'b0, 1'b0, 1'b0, 1, 0);
    dig("t5.d2", 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    for (int i = 0; i < 4; i++) idle($sformatf("t5.gapB%0d", i), 1'b0, 1'b0, 1'b0, 2, 0);
    dig("t5.d3", 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    dig("t5.d4", 1'b1, 1'b0, 1'b0, 1'b0, 4, 0);
    dig("t5.d5", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    open_hold("t5");

    // Reset mid-lockout
    enter("t6b1", 5'b00000, 0, 1'b0);
    enter("t6b2", 5'b00000, 1, 1'b0);
    enter("t6b3", 5'b00000, 2, 1'b0);
    lock_hold("t6b", 5);
    cyc("t6b.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    enter("t6b", K0, 0, 1'b1);
    open_hold("t6b");

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
